port_ingress_arbiter: RTL and testbench

Round-robin arbiter that shares the single switching datapath among all ingress ports (RMII and virtual UDP ports).
- Grants one port at a time and holds the grant for a whole frame.
- Streams that port's 9-bit bytes to the frame processor with ready/valid backpressure.
- Aborts a frame that overruns the length limit or stalls.
- Sits between the per-port receive queues and the frame processor that performs the CAM lookup.

---
 rtl/port_ingress_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_port_ingress_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_ingress_arbiter.sv
// Round-robin ingress arbiter: grants one port per frame and streams its
// 9-bit bytes (bit 8 = end-of-frame) to the frame processor.
//
// Ports:
//   clock, reset_n             core clock, async active-low reset
//   port_receive_data[N][9]    per-port byte, bit 8 = end-of-frame
//   port_receive_data_valid[N] per-port byte available
//   port_receive_data_ready[N] per-port pop, one-hot or zero
//   frame_data/_valid/_ready   muxed byte stream of the granted port
//   frame_port                 granted port index, stable for a frame
//   frame_start                pulse on the first byte transfer of a frame
//   frame_abort                pulse when a frame is aborted
//
// Optional build macro PORT_INGRESS_ARBITER_STATS_EN adds
//   frames_forwarded_count, frames_aborted_count, last_abort_port.
module port_ingress_arbiter #(
  parameter int NUMBER_OF_PORTS      = 2,
  parameter int MAX_FRAME_BYTES      = 1522,
  parameter int STALL_TIMEOUT_CYCLES = 1024,
  parameter int PORT_INDEX_WIDTH     = $clog2(NUMBER_OF_PORTS)
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [NUMBER_OF_PORTS-1:0][8:0]       port_receive_data,
  input  logic [NUMBER_OF_PORTS-1:0]            port_receive_data_valid,
  output logic [NUMBER_OF_PORTS-1:0]            port_receive_data_ready,
  output logic [8:0]                            frame_data,
  output logic                                  frame_data_valid,
  input  logic                                  frame_data_ready,
  output logic [PORT_INDEX_WIDTH-1:0]           frame_port,
  output logic                                  frame_start,
  output logic                                  frame_abort
`ifdef PORT_INGRESS_ARBITER_STATS_EN
  ,
  output logic [31:0]                           frames_forwarded_count,
  output logic [31:0]                           frames_aborted_count,
  output logic [PORT_INDEX_WIDTH-1:0]           last_abort_port
`endif
);

  localparam int PW     = PORT_INDEX_WIDTH;
  localparam int BCW_R  = $clog2(MAX_FRAME_BYTES + 1);
  localparam int BCW    = (BCW_R > 11) ? BCW_R : 11;
  localparam int SCW_R  = $clog2(STALL_TIMEOUT_CYCLES + 1);
  localparam int SCW    = (SCW_R > 1) ? SCW_R : 1;

  localparam logic [BCW-1:0] BC_MAX = BCW'(MAX_FRAME_BYTES);
  localparam logic [SCW-1:0] SC_MAX = SCW'(STALL_TIMEOUT_CYCLES);
  localparam logic [PW:0]    N_C    = (PW+1)'(NUMBER_OF_PORTS);
  localparam logic [PW-1:0]  LAST   = PW'(NUMBER_OF_PORTS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_ABORT  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [PW-1:0]  rr_q, rr_d;
  logic [PW-1:0]  port_q, port_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [SCW-1:0] stall_q, stall_d;

  logic [8:0]     gdata;
  logic           gvalid;
  logic           xfer;
  logic [BCW-1:0] bcnt_inc;
  logic [PW-1:0]  port_nxt;
  logic           pick_found;
  logic [PW-1:0]  pick_idx;
  logic [PW:0]    cand;

  assign gdata    = port_receive_data[port_q];
  assign gvalid   = port_receive_data_valid[port_q];
  assign bcnt_inc = (&bcnt_q) ? bcnt_q : bcnt_q + BCW'(1);
  assign port_nxt = (port_q == LAST) ? '0 : port_q + PW'(1);
  assign frame_port = port_q;

  // First requester at or after rr_q, scanning with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
      cand = {1'b0, rr_q} + (PW+1)'(i);
      if (cand >= N_C) cand = cand - N_C;
      if (!pick_found &&
          port_receive_data_valid[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    port_d  = port_q;
    bcnt_d  = bcnt_q;
    stall_d = stall_q;
    frame_data              = '0;
    frame_data_valid        = 1'b0;
    port_receive_data_ready = '0;
    frame_start             = 1'b0;
    frame_abort             = 1'b0;
    xfer                    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bcnt_d  = '0;
        stall_d = '0;
        if (pick_found) begin
          port_d  = pick_idx;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        frame_data       = gdata;
        frame_data_valid = gvalid;
        port_receive_data_ready[port_q] = frame_data_ready;
        xfer        = gvalid & frame_data_ready;
        frame_start = xfer && (bcnt_q == '0);
        if (xfer) begin
          bcnt_d  = bcnt_inc;
          stall_d = '0;
          // End-of-frame beats the length limit on the same byte.
          if (gdata[8]) begin
            state_d = ST_IDLE;
            rr_d    = port_nxt;
          end else if (bcnt_inc == BC_MAX) begin
            state_d = ST_ABORT;
          end
        end else if (!gvalid) begin
          // Valid high with ready low is backpressure, not a stall.
          stall_d = stall_q + SCW'(1);
          if (stall_d == SC_MAX) state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        frame_abort = 1'b1;
        rr_d        = port_nxt;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      port_q  <= '0;
      bcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      port_q  <= port_d;
      bcnt_q  <= bcnt_d;
      stall_q <= stall_d;
    end
  end

`ifdef PORT_INGRESS_ARBITER_STATS_EN
  logic [31:0]   fwd_q;
  logic [31:0]   abt_q;
  logic [PW-1:0] lap_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwd_q <= '0;
      abt_q <= '0;
      lap_q <= '0;
    end else begin
      if ((state_q == ST_STREAM) && xfer && gdata[8])
        fwd_q <= fwd_q + 32'd1;
      if ((state_q == ST_STREAM) && (state_d == ST_ABORT)) begin
        abt_q <= abt_q + 32'd1;
        lap_q <= port_q;
      end
    end
  end

  assign frames_forwarded_count = fwd_q;
  assign frames_aborted_count   = abt_q;
  assign last_abort_port        = lap_q;
`endif

endmodule

// File: tb/tb_port_ingress_arbiter.sv
// Self-checking bench for port_ingress_arbiter (4 ports, 64-byte limit,
// 8-cycle stall timeout) with a per-cycle reference model.
module tb_port_ingress_arbiter;

  localparam int N     = 4;
  localparam int MAXB  = 64;
  localparam int STALL = 8;
  localparam int PW    = 2;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [N-1:0][8:0]  prd;
  logic [N-1:0]       prv;
  logic [N-1:0]       prr;
  logic [8:0]         fd;
  logic               fdv;
  logic               fdr;
  logic [PW-1:0]      fp;
  logic               fs;
  logic               fa;
`ifdef PORT_INGRESS_ARBITER_STATS_EN
  logic [31:0]        ffc;
  logic [31:0]        fac;
  logic [PW-1:0]      lap;
`endif

  always #5 clock = ~clock;

  port_ingress_arbiter #(
    .NUMBER_OF_PORTS      (N),
    .MAX_FRAME_BYTES      (MAXB),
    .STALL_TIMEOUT_CYCLES (STALL)
  ) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .port_receive_data       (prd),
    .port_receive_data_valid (prv),
    .port_receive_data_ready (prr),
    .frame_data              (fd),
    .frame_data_valid        (fdv),
    .frame_data_ready        (fdr),
    .frame_port              (fp),
    .frame_start             (fs),
    .frame_abort             (fa)
`ifdef PORT_INGRESS_ARBITER_STATS_EN
    ,
    .frames_forwarded_count  (ffc),
    .frames_aborted_count    (fac),
    .last_abort_port         (lap)
`endif
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stimulus: per-port byte queues plus optional valid drop windows.
  logic [8:0] srcq [N][$];
  int pops [N];
  int drop_at [N];
  int drop_len [N];
  int gapc [N];
  bit rdy_toggle = 1'b0;
  int cyc = 0;

  // Observations of DUT behaviour.
  int          st_port [$];
  int          st_cyc [$];
  int          eof_cyc [$];
  int          ab_cyc [$];
  int          ab_ndel [$];
  logic [10:0] del [$];
  logic [N-1:0] rdy_or;
  int          mask_start;

  // Reference model: 0 waiting, 1 in frame, 2 aborting.
  int          m_phase = 0;
  int          m_port = 0;
  int          m_next = 0;
  int          m_cnt = 0;
  int          m_stall = 0;
  logic [31:0] m_fwd = 0;
  logic [31:0] m_abt = 0;
  int          m_last = 0;

  logic [8:0]    e_fd;
  logic          e_fdv;
  logic [N-1:0]  e_rdy;
  logic [PW-1:0] e_fp;
  logic          e_fs;
  logic          e_fa;

  initial begin
    bit masked [N];
    bit found;
    bit x;
    logic [8:0] b;
    forever begin
      @(negedge clock);
      cyc++;
      for (int p = 0; p < N; p++) begin
        masked[p] = (pops[p] == drop_at[p]) && (gapc[p] < drop_len[p]);
        prv[p] = !masked[p] && (srcq[p].size() > 0);
        prd[p] = (srcq[p].size() > 0) ? srcq[p][0] : 9'h0;
      end
      fdr = rdy_toggle ? cyc[0] : 1'b1;
      #1;
      e_fd = '0; e_fdv = 1'b0; e_rdy = '0;
      e_fs = 1'b0; e_fa = 1'b0;
      x = 1'b0;
      if (!reset_n) begin
        m_phase = 0; m_port = 0; m_next = 0;
        m_fwd = 0; m_abt = 0; m_last = 0;
      end else if (m_phase == 1) begin
        e_fd  = prd[m_port];
        e_fdv = prv[m_port];
        e_rdy[m_port] = fdr;
        x = prv[m_port] && fdr;
        e_fs = x && (m_cnt == 0);
      end else if (m_phase == 2) begin
        e_fa = 1'b1;
      end
      e_fp = PW'(m_port);
      check("outputs", {fd, fdv, prr, fp, fs, fa},
            {e_fd, e_fdv, e_rdy, e_fp, e_fs, e_fa});
`ifdef PORT_INGRESS_ARBITER_STATS_EN
      check("stats", {ffc, fac, lap}, {m_fwd, m_abt, PW'(m_last)});
`endif
      if (fdv && fdr) begin
        del.push_back({fp, fd});
        if (fs) begin
          st_port.push_back(int'(fp));
          st_cyc.push_back(cyc);
        end
        if (fd[8]) eof_cyc.push_back(cyc);
      end
      if (fa) begin
        ab_cyc.push_back(cyc);
        ab_ndel.push_back(del.size());
      end
      rdy_or |= prr;
      if (reset_n) begin
        for (int p = 0; p < N; p++)
          if (masked[p]) begin
            if (gapc[p] == 0) mask_start = cyc;
            gapc[p]++;
          end
        case (m_phase)
          0: begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
              int p;
              p = (m_next + i) % N;
              if (!found && prv[p]) begin
                found = 1'b1;
                m_port = p;
              end
            end
            if (found) begin
              m_phase = 1; m_cnt = 0; m_stall = 0;
            end
          end
          1: begin
            if (x) begin
              b = srcq[m_port].pop_front();
              pops[m_port]++;
              m_cnt++;
              m_stall = 0;
              if (b[8]) begin
                m_phase = 0;
                m_next = (m_port + 1) % N;
                m_fwd++;
              end else if (m_cnt == MAXB) begin
                m_phase = 2; m_abt++; m_last = m_port;
              end
            end else if (!prv[m_port]) begin
              m_stall++;
              if (m_stall == STALL) begin
                m_phase = 2; m_abt++; m_last = m_port;
              end
            end
          end
          default: begin
            m_next = (m_port + 1) % N;
            m_phase = 0;
          end
        endcase
      end
    end
  end

  function automatic logic [8:0] byte_of(int p, int i, bit eof);
    return {eof, 8'((p * 37 + i) & 255)};
  endfunction

  task automatic push_frame(int p, int len, bit eof_last);
    for (int i = 0; i < len; i++)
      srcq[p].push_back(byte_of(p, i, eof_last && (i == len - 1)));
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    for (int p = 0; p < N; p++) begin
      srcq[p].delete();
      pops[p] = 0; gapc[p] = 0;
      drop_at[p] = -1; drop_len[p] = 0;
    end
    rdy_toggle = 1'b0;
    st_port.delete(); st_cyc.delete(); eof_cyc.delete();
    ab_cyc.delete(); ab_ndel.delete(); del.delete();
    rdy_or = '0;
    mask_start = 0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < N; p++)
      if (srcq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_quiet(string name, int budget);
    int k = 0;
    while (!(all_empty() && m_phase == 0) && k < budget) begin
      @(posedge clock);
      k++;
    end
    check({name, " timeout"}, 64'(k < budget), 64'd1);
    repeat (3) @(posedge clock);
  endtask

  task automatic wait_del(int n, int budget);
    int k = 0;
    while (del.size() < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    check("wait_del timeout", 64'(k < budget), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int n0;
    reset_n = 1'b1;
    for (int p = 0; p < N; p++) begin
      drop_at[p] = -1; drop_len[p] = 0; pops[p] = 0; gapc[p] = 0;
    end
    #1 reset_n = 1'b0;
    #1;
    check("reset valid", 64'(fdv), 0);
    check("reset ready", 64'(prr), 0);
    check("reset data", 64'(fd), 0);
    check("reset port", 64'(fp), 0);
    check("reset start/abort", 64'({fs, fa}), 0);

    // 1: single 64-byte frame on port 2, end-of-frame on the limit byte
    do_reset();
    push_frame(2, 64, 1'b1);
    wait_quiet("t1", 400);
    check("t1 starts", st_port.size(), 1);
    check("t1 port", st_port[0], 2);
    check("t1 bytes", del.size(), 64);
    check("t1 last eof", 64'(del[63][8]), 1);
    check("t1 eofs", eof_cyc.size(), 1);
    check("t1 aborts", ab_cyc.size(), 0);
    check("t1 ready mask", 64'(rdy_or), 64'(4'b0100));
    check("t1 model rr", m_next, 3);
    check("t1 port held", 64'(fp), 2);

    // 2: all ports busy with 3-byte frames
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) push_frame(p, 3, 1'b1);
    wait_quiet("t2", 400);
    begin
      int exp_ord [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) check("t2 order", st_port[i], exp_ord[i]);
    end
    for (int i = 1; i < 8; i++)
      check("t2 gap", st_cyc[i] - eof_cyc[i - 1], 2);
    check("t2 aborts", ab_cyc.size(), 0);

    // 3: downstream ready toggles every cycle
    do_reset();
    rdy_toggle = 1'b1;
    push_frame(1, 10, 1'b1);
    wait_quiet("t3", 400);
    rdy_toggle = 1'b0;
    check("t3 bytes", del.size(), 10);
    errs = 0;
    for (int i = 0; i < 10; i++)
      if (del[i] !== {2'd1, byte_of(1, i, i == 9)}) errs++;
    check("t3 order errors", errs, 0);
    check("t3 aborts", ab_cyc.size(), 0);
    check("t3 ready mask", 64'(rdy_or), 64'(4'b0010));

    // 4: overlong frame on port 0, port 1 waiting
    do_reset();
    push_frame(0, 70, 1'b0);
    push_frame(1, 3, 1'b1);
    wait_quiet("t4", 600);
    check("t4 aborts", ab_cyc.size(), 2);
    check("t4 bytes before abort", ab_ndel[0], 64);
    check("t4 next port", st_port[1], 1);
    check("t4 regrant", st_port[2], 0);
    check("t4 abort to start", st_cyc[1] - ab_cyc[0], 2);
    check("t4 total bytes", del.size(), 73);
    check("t4 model aborts", 64'(m_abt), 2);

    // 5a: port 3 valid drops for 8 cycles mid-frame
    do_reset();
    push_frame(3, 20, 1'b1);
    drop_at[3] = 5; drop_len[3] = 8;
    wait_quiet("t5a", 400);
    check("t5a aborts", ab_cyc.size(), 1);
    check("t5a abort timing", ab_cyc[0] - mask_start, 8);
    check("t5a bytes before abort", ab_ndel[0], 5);
    check("t5a regrant port", st_port[1], 3);
    check("t5a bytes", del.size(), 20);

    // 5b: 7-cycle drop is tolerated
    do_reset();
    push_frame(3, 20, 1'b1);
    drop_at[3] = 5; drop_len[3] = 7;
    wait_quiet("t5b", 400);
    check("t5b aborts", ab_cyc.size(), 0);
    check("t5b starts", st_port.size(), 1);
    check("t5b bytes", del.size(), 20);

    // 6: asynchronous reset in the middle of a frame
    do_reset();
    push_frame(1, 3, 1'b1);
    push_frame(2, 30, 1'b1);
    wait_del(13, 200);
    push_frame(0, 3, 1'b1);
    push_frame(3, 3, 1'b1);
`ifdef PORT_INGRESS_ARBITER_STATS_EN
    check("t6 fwd before", 64'(ffc), 1);
`endif
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 valid", 64'(fdv), 0);
    check("t6 ready", 64'(prr), 0);
    check("t6 abort", 64'(fa), 0);
    check("t6 data/port/start", 64'({fd, fp, fs}), 0);
`ifdef PORT_INGRESS_ARBITER_STATS_EN
    check("t6 stats cleared", 64'({ffc, fac}), 0);
`endif
    n0 = st_port.size();
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    wait_quiet("t6", 400);
    check("t6 first after reset", st_port[n0], 0);
    check("t6 second", st_port[n0 + 1], 2);
    check("t6 third", st_port[n0 + 2], 3);
    check("t6 no aborts", ab_cyc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
